// File: rtl/ack_formatter.sv
// ack_formatter: formats duration_ms as the ASCII line "ACK <decimal>\n" on a valid/ready byte stream
//   clk, rst          system clock, synchronous active-high reset
//   start             request; accepted when idle, captures duration_ms
//   duration_ms       unsigned binary value to format
//   busy              high from accepted start until done
//   tx_data/tx_valid  byte to the UART transmitter, held until tx_ready
//   tx_ready          transmitter accepts tx_data this cycle
//   done              one-cycle pulse after the '\n' byte transfers
//   ACK_FORMATTER_SHORT_ZERO_EN  when defined, a zero value emits "ACK \n"
module ack_formatter #(
  parameter int VALUE_WIDTH = 32,
  parameter int DIGITS = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [VALUE_WIDTH-1:0] duration_ms,
  output logic                   busy,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   done
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(VALUE_WIDTH + 1);
  localparam int NW = $clog2(DIGITS + 1);
  typedef enum logic [2:0] {IDLE, CONVERT, NORMALIZE, PREFIX, NUM, NEWLINE} state_t;
  state_t state_q, state_d;
  logic [VALUE_WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0] bcd_q, bcd_d, adj;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NW-1:0] count_q, count_d;
  logic busy_q, busy_d, tx_valid_q, tx_valid_d, done_q, done_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic [3:0] top;
  logic skip;
  assign top = bcd_q[BW-1 -: 4];
`ifdef ACK_FORMATTER_SHORT_ZERO_EN
  assign skip = count_q == NW'(1) && top == 4'd0;
`else
  assign skip = 1'b0;
`endif
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    state_d = state_q;
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    count_d = count_q;
    busy_d = busy_q;
    tx_valid_d = tx_valid_q;
    tx_data_d = tx_data_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = CONVERT;
        busy_d = 1'b1;
        bin_d = duration_ms;
        bcd_d = '0;
        cnt_d = '0;
      end
      CONVERT: begin
        {bcd_d, bin_d} = {adj, bin_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(VALUE_WIDTH - 1)) begin
          state_d = NORMALIZE;
          cnt_d = '0;
          count_d = NW'(DIGITS);
        end
      end
      NORMALIZE: begin
        if (top == 4'd0 && count_q > NW'(1)) begin
          bcd_d = bcd_q << 4;
          count_d = count_q - 1'b1;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DIGITS - 2)) begin
          state_d = PREFIX;
          cnt_d = '0;
        end
      end
      PREFIX: if (!tx_valid_q) begin
        tx_valid_d = 1'b1;
        tx_data_d = 8'h41;
      end else if (tx_ready) begin
        cnt_d = cnt_q + 1'b1;
        tx_data_d = cnt_q == CW'(0) ? 8'h43 : cnt_q == CW'(1) ? 8'h4B : 8'h20;
        if (cnt_q == CW'(3)) begin
          state_d = skip ? NEWLINE : NUM;
          tx_data_d = skip ? 8'h0A : {4'h3, top};
          bcd_d = bcd_q << 4;
        end
      end
      NUM: if (tx_ready) begin
        state_d = count_q == NW'(1) ? NEWLINE : NUM;
        tx_data_d = count_q == NW'(1) ? 8'h0A : {4'h3, top};
        bcd_d = bcd_q << 4;
        count_d = count_q - 1'b1;
      end
      NEWLINE: if (tx_ready) begin
        state_d = IDLE;
        tx_valid_d = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      count_q <= '0;
      busy_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q <= 8'h00;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      count_q <= count_d;
      busy_q <= busy_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q <= tx_data_d;
      done_q <= done_d;
    end
  end
  assign busy = busy_q;
  assign tx_valid = tx_valid_q;
  assign tx_data = tx_data_q;
  assign done = done_q;
endmodule

// File: tb/tb_ack_formatter.sv
// tb_ack_formatter: directed scenario bench for ack_formatter
module tb_ack_formatter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic tx_ready = 1'b0;
  logic [31:0] duration_ms = '0;
  logic busy, tx_valid, done;
  logic [7:0] tx_data;
  int errors = 0;
  int checks = 0;
  logic [7:0] rx[$];
  int lat, drops, stalls;
  logic done_o, busy_o, valid_o;
  always #5 clk = ~clk;
  ack_formatter dut (
    .clk(clk), .rst(rst), .start(start), .duration_ms(duration_ms), .busy(busy),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .done(done)
  );
  function automatic int first_diff(string s);
    if (rx.size() != s.len()) return rx.size();
    for (int i = 0; i < s.len(); i++) if (rx[i] !== s[i]) return i;
    return -1;
  endfunction
  function automatic string rx_str();
    string r = "";
    for (int i = 0; i < rx.size() && i < 40; i++) r = {r, $sformatf("%02h ", rx[i])};
    return r;
  endfunction
  task automatic run_msg(input logic [31:0] v, input int period, input bit poke);
    bit held_v = 0;
    bit fin = 0;
    logic [7:0] held = '0;
    int cyc = 0;
    rx.delete();
    drops = 0;
    stalls = 0;
    duration_ms = v;
    start = 1'b1;
    tx_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!tx_valid && lat < 200) begin
      @(negedge clk);
      lat++;
      if (poke && lat == 5) begin
        start = 1'b1;
        duration_ms = 32'd999;
      end else start = 1'b0;
    end
    start = 1'b0;
    for (int k = 0; k < 500 && !fin; k++) begin
      if (!tx_valid) drops++;
      if (held_v && tx_data !== held) stalls++;
      tx_ready = (cyc % period) == 0;
      cyc++;
      if (tx_ready && tx_valid) begin
        rx.push_back(tx_data);
        held_v = 0;
        fin = tx_data == 8'h0A;
      end else begin
        held_v = tx_valid;
        held = tx_data;
      end
      @(negedge clk);
    end
    tx_ready = 1'b0;
    done_o = done;
    busy_o = busy;
    valid_o = tx_valid;
  endtask
  task automatic check_bytes(input string name, input string s);
    checks++;
    if (first_diff(s) != -1) begin
      errors++;
      $display("FAIL %s: got %s required %d bytes of \"%s\"", name, rx_str(), s.len(), s);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 4;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", tx_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
    if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h required 00", tx_data); end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_basic();
    run_msg(32'd250, 1, 0);
    check_bytes("basic_bytes", "ACK 250\n");
    checks += 6;
    if (lat !== 42) begin errors++; $display("FAIL basic_latency: got %0d required 42", lat); end
    if (drops !== 0) begin errors++; $display("FAIL basic_bubbles: got %0d required 0", drops); end
    if (done_o !== 1'b1) begin errors++; $display("FAIL basic_done: got %b required 1", done_o); end
    if (busy_o !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b required 0", busy_o); end
    if (valid_o !== 1'b0) begin errors++; $display("FAIL basic_valid_after: got %b required 0", valid_o); end
    @(negedge clk);
    if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b required 0", done); end
  endtask
  task automatic test_zero();
    run_msg(32'd0, 1, 0);
`ifdef ACK_FORMATTER_SHORT_ZERO_EN
    check_bytes("zero_bytes", "ACK \n");
`else
    check_bytes("zero_bytes", "ACK 0\n");
`endif
    checks += 2;
    if (done_o !== 1'b1) begin errors++; $display("FAIL zero_done: got %b required 1", done_o); end
    if (lat !== 42) begin errors++; $display("FAIL zero_latency: got %0d required 42", lat); end
    @(negedge clk);
  endtask
  task automatic test_max();
    run_msg(32'hFFFF_FFFF, 1, 0);
    check_bytes("max_bytes", "ACK 4294967295\n");
    checks += 2;
    if (rx.size() !== 15) begin errors++; $display("FAIL max_length: got %0d required 15", rx.size()); end
    if (lat !== 42) begin errors++; $display("FAIL max_latency: got %0d required 42", lat); end
    @(negedge clk);
  endtask
  task automatic test_stall();
    run_msg(32'd7, 3, 0);
    check_bytes("stall_bytes", "ACK 7\n");
    checks += 2;
    if (stalls !== 0) begin errors++; $display("FAIL stall_hold: got %0d changes required 0", stalls); end
    if (drops !== 0) begin errors++; $display("FAIL stall_drop: got %0d required 0", drops); end
    @(negedge clk);
  endtask
  task automatic test_busy_ignore();
    run_msg(32'd42, 1, 1);
    check_bytes("busy_ignore_bytes", "ACK 42\n");
    @(negedge clk);
  endtask
  task automatic test_reset_mid();
    int w = 0;
    duration_ms = 32'd99999;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!tx_valid && w < 200) begin @(negedge clk); w++; end
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks += 2;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b required 0", tx_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b required 0", busy); end
    rst = 1'b0;
    tx_ready = 1'b0;
    @(negedge clk);
    run_msg(32'd12, 1, 0);
    check_bytes("after_reset_bytes", "ACK 12\n");
    @(negedge clk);
  endtask
  task automatic test_back_to_back();
    run_msg(32'd3, 1, 0);
    check_bytes("b2b_first_bytes", "ACK 3\n");
    run_msg(32'd5, 1, 0);
    check_bytes("b2b_second_bytes", "ACK 5\n");
    checks++;
    if (lat !== 42) begin errors++; $display("FAIL b2b_latency: got %0d required 42", lat); end
    @(negedge clk);
  endtask
  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_max();
    test_stall();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
